// File: rtl/group_tally.sv
// Multi-channel BCD tally: each valid word steps its selected channel up or down, rejected words raise a sticky warning.
// Optional macro GROUP_TALLY_WRAP_EN makes counts wrap at 0 / MAX_COUNT instead of saturating.
module group_tally #(
  parameter int CHANNELS  = 2,
  parameter int WORD_W    = 5,
  parameter int RUN_LEN   = 2,
  parameter int MAX_COUNT = 20
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    valid,
  input  logic [WORD_W-1:0]       word,
  input  logic [2:0]              selection,
  input  logic                    mode,
  input  logic                    warn_clr,
  output logic [4*CHANNELS-1:0]   tens,
  output logic [4*CHANNELS-1:0]   ones,
  output logic                    warning,
  output logic [7:0]              warn_cnt
);

`ifdef GROUP_TALLY_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [3:0] CH_L    = 4'(CHANNELS);
  localparam logic [7:0] MAX_BCD = {4'(MAX_COUNT / 10), 4'(MAX_COUNT % 10)};

  // True when w holds at least RUN_LEN consecutive bits equal to t.
  function automatic logic has_run(input logic [WORD_W-1:0] w, input logic t);
    logic hit;
    int   run;
    hit = 1'b0;
    run = 0;
    for (int i = 0; i < WORD_W; i++) begin
      run = (w[i] == t) ? run + 1 : 0;
      if (run >= RUN_LEN) hit = 1'b1;
    end
    return hit;
  endfunction

  // One BCD step of a {tens, ones} pair, with wrap or saturation at the limits.
  function automatic logic [7:0] bcd_step(input logic [7:0] cur, input logic up);
    logic [3:0] t;
    logic [3:0] o;
    logic [7:0] nxt;
    t   = cur[7:4];
    o   = cur[3:0];
    nxt = cur;
    if (up) begin
      if (cur == MAX_BCD)  nxt = WRAP ? 8'h00 : cur;
      else if (o == 4'd9)  nxt = {t + 4'd1, 4'd0};
      else                 nxt = {t, o + 4'd1};
    end else begin
      if (cur == 8'h00)    nxt = WRAP ? MAX_BCD : cur;
      else if (o == 4'd0)  nxt = {t - 4'd1, 4'd9};
      else                 nxt = {t, o - 4'd1};
    end
    return nxt;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic sel_ok;
  logic word_ok;
  logic vld_p0;
  logic acc_p0;
  logic rej_p0;

  assign sel_ok  = ({1'b0, selection} < CH_L);
  assign word_ok = has_run(word, selection[0]);
  assign vld_p0  = valid;
  assign acc_p0  = vld_p0 & sel_ok & word_ok;
  assign rej_p0  = vld_p0 & ~(sel_ok & word_ok);

  // p0 -> outputs: per-channel count registers
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0] cnt_p0;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        cnt_p0 <= 8'h00;
      end else if (acc_p0 && (selection == 3'(c))) begin
        cnt_p0 <= bcd_step(cnt_p0, mode);
      end
    end

    assign tens[4*c +: 4] = cnt_p0[7:4];
    assign ones[4*c +: 4] = cnt_p0[3:0];
  end

  // A rejection in the same cycle as warn_clr keeps the flag set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      warning  <= 1'b0;
      warn_cnt <= 8'h00;
    end else begin
      if (rej_p0)        warning <= 1'b1;
      else if (warn_clr) warning <= 1'b0;
      if (rej_p0)        warn_cnt <= sat_inc8(warn_cnt);
    end
  end

endmodule

// File: tb/tb_group_tally.sv
// Scoreboard bench for group_tally: default instance plus a 4-channel/8-bit/run-3 instance.
// Honors GROUP_TALLY_WRAP_EN the same way as the design.
module tb_group_tally;

`ifdef GROUP_TALLY_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int MAXC = 20;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST_N;

  logic v0, m0, c0;
  logic [4:0] w0;
  logic [2:0] s0;
  logic [7:0] t0, o0, wc0;
  logic wr0;

  logic v1, m1, c1;
  logic [7:0] w1;
  logic [2:0] s1;
  logic [15:0] t1, o1;
  logic [7:0] wc1;
  logic wr1;

  group_tally dut0 (
    .CLK(CLK), .RST_N(RST_N), .valid(v0), .word(w0), .selection(s0), .mode(m0),
    .warn_clr(c0), .tens(t0), .ones(o0), .warning(wr0), .warn_cnt(wc0)
  );

  group_tally #(.CHANNELS(4), .WORD_W(8), .RUN_LEN(3), .MAX_COUNT(MAXC)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .valid(v1), .word(w1), .selection(s1), .mode(m1),
    .warn_clr(c1), .tens(t1), .ones(o1), .warning(wr1), .warn_cnt(wc1)
  );

  typedef struct packed {
    logic [7:0]  t0;
    logic [7:0]  o0;
    logic        wr0;
    logic [7:0]  wc0;
    logic [15:0] t1;
    logic [15:0] o1;
    logic        wr1;
    logic [7:0]  wc1;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integer counts per channel.
  int cnt[2][8];
  bit mw[2];
  int mwc[2];
  int P_CH[2] = '{2, 4};
  int P_WW[2] = '{5, 8};
  int P_RL[2] = '{2, 3};

  function automatic bit run_ok(int inst, logic [15:0] w, bit t);
    bit all;
    for (int i = 0; i + P_RL[inst] <= P_WW[inst]; i++) begin
      all = 1'b1;
      for (int j = 0; j < P_RL[inst]; j++)
        if (w[i+j] !== t) all = 1'b0;
      if (all) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 8; c++) cnt[i][c] = 0;
      mw[i]  = 1'b0;
      mwc[i] = 0;
    end
  endfunction

  function automatic void model_apply(int inst, bit v, logic [15:0] w, logic [2:0] s, bit m, bit clr);
    bit acc;
    if (clr) mw[inst] = 1'b0;
    if (v) begin
      acc = (int'(s) < P_CH[inst]) && run_ok(inst, w, s[0]);
      if (acc) begin
        if (m) cnt[inst][s] = (cnt[inst][s] == MAXC) ? (WRAP ? 0 : MAXC) : cnt[inst][s] + 1;
        else   cnt[inst][s] = (cnt[inst][s] == 0) ? (WRAP ? MAXC : 0) : cnt[inst][s] - 1;
      end else begin
        mw[inst] = 1'b1;
        if (mwc[inst] < 255) mwc[inst]++;
      end
    end
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e = '0;
    for (int c = 0; c < 2; c++) begin
      e.t0[4*c +: 4] = 4'(cnt[0][c] / 10);
      e.o0[4*c +: 4] = 4'(cnt[0][c] % 10);
    end
    for (int c = 0; c < 4; c++) begin
      e.t1[4*c +: 4] = 4'(cnt[1][c] / 10);
      e.o1[4*c +: 4] = 4'(cnt[1][c] % 10);
    end
    e.wr0 = mw[0];
    e.wc0 = 8'(mwc[0]);
    e.wr1 = mw[1];
    e.wc1 = 8'(mwc[1]);
    return e;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void compare_all(exp_t e, string tag);
    check({tag, "_tens0"}, 32'(t0), 32'(e.t0));
    check({tag, "_ones0"}, 32'(o0), 32'(e.o0));
    check({tag, "_warn0"}, 32'(wr0), 32'(e.wr0));
    check({tag, "_wcnt0"}, 32'(wc0), 32'(e.wc0));
    check({tag, "_tens1"}, 32'(t1), 32'(e.t1));
    check({tag, "_ones1"}, 32'(o1), 32'(e.o1));
    check({tag, "_warn1"}, 32'(wr1), 32'(e.wr1));
    check({tag, "_wcnt1"}, 32'(wc1), 32'(e.wc1));
  endfunction

  // Monitor: one expected snapshot per driven edge, sampled after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare_all(e, "sb");
      end
    end
  end

  task automatic step(int inst, bit v, logic [15:0] w, logic [2:0] s, bit m, bit clr);
    logic [15:0] wm;
    @(negedge CLK);
    v0 = 1'b0; c0 = 1'b0; v1 = 1'b0; c1 = 1'b0;
    wm = (inst == 0) ? (w & 16'h001F) : (w & 16'h00FF);
    if (inst == 0) begin
      v0 = v; w0 = wm[4:0]; s0 = s; m0 = m; c0 = clr;
    end else begin
      v1 = v; w1 = wm[7:0]; s1 = s; m1 = m; c1 = clr;
    end
    model_apply(inst, v, wm, s, m, clr);
    q.push_back(snapshot());
  endtask

  task automatic flush();
    step(0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 8 && q.size() != 0; k++) begin
      @(posedge CLK);
      #3;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #1 RST_N = 1'b0;
    #1 model_reset();
    compare_all(snapshot(), "rst_async");
    #1 RST_N = 1'b1;
  endtask

  task automatic reset_midstream();
    @(negedge CLK);
    v0 = 1'b1; w0 = 5'b10011; s0 = 3'd0; m0 = 1'b1; c0 = 1'b0;
    RST_N = 1'b0;
    model_reset();
    @(posedge CLK);
    #3 compare_all(snapshot(), "rst_mid");
    @(negedge CLK);
    v0 = 1'b0;
    RST_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    v0 = 0; w0 = '0; s0 = '0; m0 = 0; c0 = 0;
    v1 = 0; w1 = '0; s1 = '0; m1 = 0; c1 = 0;
    model_reset();
    #2 compare_all(snapshot(), "rst_init");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Twelve up-steps on channel 0
    for (int i = 0; i < 12; i++) step(0, 1'b1, 16'b10011, 3'd0, 1'b1, 1'b0);
    flush();
    check("r32_tens", 32'(t0), 32'h01);
    check("r32_ones", 32'(o0), 32'h02);
    check("r32_warn", 32'(wr0), 32'd0);

    // Channel 1 up to the limit and one beyond
    pulse_reset();
    for (int i = 0; i < 20; i++) step(0, 1'b1, 16'b01100, 3'd1, 1'b1, 1'b0);
    flush();
    check("r33_tens20", 32'(t0), 32'h20);
    check("r33_ones20", 32'(o0), 32'h00);
    step(0, 1'b1, 16'b01100, 3'd1, 1'b1, 1'b0);
    flush();
    check("r33_tens21", 32'(t0), WRAP ? 32'h00 : 32'h20);

    // Down-step at zero
    pulse_reset();
    step(0, 1'b1, 16'b10001, 3'd0, 1'b0, 1'b0);
    flush();
    check("r34_tens", 32'(t0), WRAP ? 32'h02 : 32'h00);
    check("r34_ones", 32'(o0), 32'h00);
    check("r34_warn", 32'(wr0), 32'd0);

    // Rejections, sticky warning, set-wins against warn_clr
    pulse_reset();
    step(0, 1'b1, 16'b10101, 3'd0, 1'b1, 1'b0);
    step(0, 1'b1, 16'b10011, 3'd5, 1'b1, 1'b0);
    flush();
    check("r35_warn", 32'(wr0), 32'd1);
    check("r35_wcnt", 32'(wc0), 32'd2);
    check("r35_ones", 32'(o0), 32'h00);
    step(0, 1'b1, 16'b10101, 3'd0, 1'b1, 1'b1);
    flush();
    check("r35_warn_setwins", 32'(wr0), 32'd1);
    check("r35_wcnt3", 32'(wc0), 32'd3);
    step(0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
    flush();
    check("r35_clr", 32'(wr0), 32'd0);
    check("r35_wcnt_hold", 32'(wc0), 32'd3);

    // Ones rollover, async reset pulse, restart
    pulse_reset();
    for (int i = 0; i < 9; i++) step(0, 1'b1, 16'b10011, 3'd0, 1'b1, 1'b0);
    flush();
    check("r36_ones9", 32'(o0), 32'h09);
    step(0, 1'b1, 16'b10011, 3'd0, 1'b1, 1'b0);
    flush();
    check("r36_tens10", 32'(t0), 32'h01);
    pulse_reset();
    step(0, 1'b1, 16'b10011, 3'd0, 1'b1, 1'b0);
    flush();
    check("r36_after", 32'(o0), 32'h01);
    check("r36_after_t", 32'(t0), 32'h00);

    // Reset held across an edge with a valid word present
    reset_midstream();
    step(0, 1'b1, 16'b10011, 3'd0, 1'b1, 1'b0);
    flush();
    check("r28_first", 32'(o0), 32'h01);

    // Wider instance: run length 3
    step(1, 1'b1, 16'b00011100, 3'd3, 1'b1, 1'b0);
    step(1, 1'b1, 16'b00011100, 3'd2, 1'b1, 1'b0);
    step(1, 1'b1, 16'b11011011, 3'd2, 1'b1, 1'b0);
    flush();
    check("r37_ones", 32'(o1), 32'h1100);
    check("r37_warn", 32'(wr1), 32'd1);
    check("r37_wcnt", 32'(wc1), 32'd1);

    // Randomized traffic, up-heavy then down-heavy to reach both limits
    for (int i = 0; i < 600; i++) begin
      int  inst;
      bit  m;
      logic [2:0] s;
      inst = int'($urandom_range(0, 1));
      m = (i < 300) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
      s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, P_CH[inst] - 1)) : 3'($urandom_range(0, 7));
      step(inst, $urandom_range(0, 3) != 0, 16'($urandom), s, m, $urandom_range(0, 15) == 0);
    end
    flush();

    // Rejection counter saturation
    for (int i = 0; i < 260; i++) step(0, 1'b1, 16'($urandom), 3'd7, 1'b1, 1'b0);
    flush();
    check("wcnt_sat", 32'(wc0), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
